// File: rtl/gen_pkg.sv
// Shared constants for the signal-generator counters.
// Mode encodings and the default count width.
package gen_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by (div+1) into single-cycle step pulses.
// Instantiated by range_counter only when PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             step
);

    logic [DIV_W-1:0] cnt;

    // >= so a divisor lowered below the running count still terminates
    assign step = enable && !clear && (cnt >= div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt >= div) cnt <= '0;
            else            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/range_counter.sv
// Bounded up/down/triangle counter with terminal-count pulse.
// Optional prescaler on the step enable: define PRESCALE_EN.
module range_counter
    import gen_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int RESET_VAL = 1,
    parameter int DIV_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef PRESCALE_EN
    input  logic [DIV_W-1:0] div,
`endif
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc
);

    logic             step;
    logic             degen;
    logic             in_range;
    logic [WIDTH-1:0] nq;
    logic             ndir;
    logic             ntc;

`ifdef PRESCALE_EN
    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .div    (div),
        .clear  (load),
        .step   (step)
    );
`else
    assign step = enable;
`endif

    assign degen    = (lo >= hi);
    assign in_range = (q >= lo) && (q <= hi);

    always_comb begin
        nq   = q;
        ndir = dir;
        ntc  = 1'b0;
        if (step && mode != MODE_HOLD) begin
            unique case (1'b1)
                degen: begin
                    nq  = lo;
                    ntc = 1'b1;
                    if (mode == MODE_UP)        ndir = 1'b0;
                    else if (mode == MODE_DOWN) ndir = 1'b1;
                end
                (!degen && !in_range): begin
                    // re-enter the window after a bound change
                    if (mode == MODE_DOWN) begin
                        nq   = hi;
                        ndir = 1'b1;
                    end else begin
                        nq   = lo;
                        ndir = 1'b0;
                    end
                end
                (!degen && in_range): begin
                    unique case (mode)
                        MODE_UP: begin
                            ndir = 1'b0;
                            if (q >= hi) begin
                                nq  = lo;
                                ntc = 1'b1;
                            end else begin
                                nq = q + 1'b1;
                            end
                        end
                        MODE_DOWN: begin
                            ndir = 1'b1;
                            if (q <= lo) begin
                                nq  = hi;
                                ntc = 1'b1;
                            end else begin
                                nq = q - 1'b1;
                            end
                        end
                        MODE_UPDOWN: begin
                            if (!dir) begin
                                if (q >= hi) begin
                                    nq   = hi - 1'b1;
                                    ndir = 1'b1;
                                    ntc  = 1'b1;
                                end else begin
                                    nq = q + 1'b1;
                                end
                            end else begin
                                if (q <= lo) begin
                                    nq   = lo + 1'b1;
                                    ndir = 1'b0;
                                    ntc  = 1'b1;
                                end else begin
                                    nq = q - 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= WIDTH'(RESET_VAL);
            dir <= 1'b0;
            tc  <= 1'b0;
        end else if (load) begin
            q   <= load_val;
            dir <= 1'b0;
            tc  <= 1'b0;
        end else begin
            q   <= nq;
            dir <= ndir;
            tc  <= ntc;
        end
    end

endmodule
